// File: rtl/flash_pkg.sv
// Shared types and constants for the flash fetch front end.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER,
    COOLDOWN
  } fetch_state_t;

  // Requester identity as reported by the SPI controller on spi_mode.
  localparam logic [1:0] MODE_NONE   = 2'd0;
  localparam logic [1:0] MODE_DCACHE = 2'd1;
  localparam logic [1:0] MODE_ICACHE = 2'd2;

  // Highest CPU byte address that maps onto flash.
  localparam logic [19:0] CPU_ADDR_MAX = 20'hAFFFF;

  // Width of the WAIT-state timer.
  localparam int TIMER_W = 10;

  function automatic logic addr_in_range(input logic [19:0] addr);
    return addr <= CPU_ADDR_MAX;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating cycle counter that bounds how long a fetch may wait for data.
module fetch_timeout_counter
  import flash_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

  logic [TIMER_W-1:0] count_reg;

  // Clear wins over enable; the count sticks at LIMIT instead of wrapping.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + TIMER_W'(1);
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/flash_fetch_arbiter.sv
// Arbitrates icache/dcache word fetches onto a single SPI flash controller,
// with dcache priority, an icache starvation guard, range checking, abort
// handling and a fetch timeout.
module flash_fetch_arbiter
  import flash_pkg::*;
#(
  parameter int TIMEOUT    = 1023,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        icache_req,
  input  logic [19:0] icache_addr,
  output logic        icache_ack,
  output logic [31:0] icache_rdata,
  input  logic        dcache_req,
  input  logic [19:0] dcache_addr,
  output logic        dcache_ack,
  output logic [31:0] dcache_rdata,
  output logic        fetch_err,
  output logic        err_sticky,
  output logic        spi_icache_miss,
  output logic        spi_dcache_miss,
  output logic [19:0] spi_addr,
  input  logic [1:0]  spi_mode,
  input  logic        spi_data_ready,
  input  logic [31:0] spi_data
);

  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  fetch_state_t        state_reg, state_next;
  logic                grant_icache_reg, grant_icache_next;
  logic [19:0]         addr_reg, addr_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic                icache_miss_reg, icache_miss_next;
  logic                dcache_miss_reg, dcache_miss_next;
  logic                icache_ack_reg, icache_ack_next;
  logic                dcache_ack_reg, dcache_ack_next;
  logic                fetch_err_reg, fetch_err_next;
  logic                err_sticky_reg, err_sticky_next;
  logic [31:0]         icache_rdata_reg, icache_rdata_next;
  logic [31:0]         dcache_rdata_reg, dcache_rdata_next;
  logic                timer_clear, timer_enable, timer_expired;

  // The requester currently holding the grant and the mode that identifies it.
  logic       granted_req;
  logic [1:0] grant_mode;
  assign granted_req = grant_icache_reg ? icache_req : dcache_req;
  assign grant_mode  = grant_icache_reg ? MODE_ICACHE : MODE_DCACHE;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // State and registered outputs; reset drops the miss lines immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      grant_icache_reg <= 1'b0;
      addr_reg         <= '0;
      starve_reg       <= '0;
      icache_miss_reg  <= 1'b0;
      dcache_miss_reg  <= 1'b0;
      icache_ack_reg   <= 1'b0;
      dcache_ack_reg   <= 1'b0;
      fetch_err_reg    <= 1'b0;
      err_sticky_reg   <= 1'b0;
      icache_rdata_reg <= '0;
      dcache_rdata_reg <= '0;
    end else begin
      state_reg        <= state_next;
      grant_icache_reg <= grant_icache_next;
      addr_reg         <= addr_next;
      starve_reg       <= starve_next;
      icache_miss_reg  <= icache_miss_next;
      dcache_miss_reg  <= dcache_miss_next;
      icache_ack_reg   <= icache_ack_next;
      dcache_ack_reg   <= dcache_ack_next;
      fetch_err_reg    <= fetch_err_next;
      err_sticky_reg   <= err_sticky_next;
      icache_rdata_reg <= icache_rdata_next;
      dcache_rdata_reg <= dcache_rdata_next;
    end
  end

  // Next-state, arbitration and output decode. Acks are set on the transition
  // into DELIVER so they are high for exactly the DELIVER cycle.
  always_comb begin
    state_next        = state_reg;
    grant_icache_next = grant_icache_reg;
    addr_next         = addr_reg;
    starve_next       = starve_reg;
    icache_miss_next  = 1'b0;
    dcache_miss_next  = 1'b0;
    icache_ack_next   = 1'b0;
    dcache_ack_next   = 1'b0;
    fetch_err_next    = 1'b0;
    err_sticky_next   = err_sticky_reg;
    icache_rdata_next = icache_rdata_reg;
    dcache_rdata_next = dcache_rdata_reg;
    timer_clear       = 1'b0;
    timer_enable      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (icache_req || dcache_req) begin
          // dcache wins unless it has had STARVE_MAX grants in a row.
          if (icache_req && (!dcache_req || (starve_reg == STARVE_LIM))) begin
            grant_icache_next = 1'b1;
            addr_next         = icache_addr;
            starve_next       = '0;
          end else begin
            grant_icache_next = 1'b0;
            addr_next         = dcache_addr;
            if (starve_reg != STARVE_LIM) begin
              starve_next = starve_reg + STARVE_W'(1);
            end
          end
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        if (!granted_req) begin
          state_next = COOLDOWN;
        end else if (!addr_in_range(addr_reg)) begin
          // Unmapped address: answer with an error and never touch the flash.
          icache_ack_next = grant_icache_reg;
          dcache_ack_next = !grant_icache_reg;
          fetch_err_next  = 1'b1;
          err_sticky_next = 1'b1;
          state_next      = DELIVER;
        end else begin
          timer_clear      = 1'b1;
          icache_miss_next = grant_icache_reg;
          dcache_miss_next = !grant_icache_reg;
          state_next       = WAIT;
        end
      end

      WAIT: begin
        timer_enable     = 1'b1;
        icache_miss_next = grant_icache_reg;
        dcache_miss_next = !grant_icache_reg;
        if (spi_data_ready && (spi_mode == grant_mode)) begin
          if (grant_icache_reg) begin
            icache_rdata_next = spi_data;
          end else begin
            dcache_rdata_next = spi_data;
          end
          icache_ack_next  = grant_icache_reg;
          dcache_ack_next  = !grant_icache_reg;
          icache_miss_next = 1'b0;
          dcache_miss_next = 1'b0;
          state_next       = DELIVER;
        end else if (timer_expired) begin
          if (grant_icache_reg) begin
            icache_rdata_next = '0;
          end else begin
            dcache_rdata_next = '0;
          end
          icache_ack_next  = grant_icache_reg;
          dcache_ack_next  = !grant_icache_reg;
          fetch_err_next   = 1'b1;
          err_sticky_next  = 1'b1;
          icache_miss_next = 1'b0;
          dcache_miss_next = 1'b0;
          state_next       = DELIVER;
        end else if (!granted_req) begin
          // Requester gave up: release the controller silently.
          icache_miss_next = 1'b0;
          dcache_miss_next = 1'b0;
          state_next       = COOLDOWN;
        end
      end

      DELIVER: begin
        state_next = COOLDOWN;
      end

      COOLDOWN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign icache_ack      = icache_ack_reg;
  assign dcache_ack      = dcache_ack_reg;
  assign icache_rdata    = icache_rdata_reg;
  assign dcache_rdata    = dcache_rdata_reg;
  assign fetch_err       = fetch_err_reg;
  assign err_sticky      = err_sticky_reg;
  assign spi_icache_miss = icache_miss_reg;
  assign spi_dcache_miss = dcache_miss_reg;
  assign spi_addr        = addr_reg;

endmodule
